// File: rtl/tx_sched_dispatch.sv
// tx_sched_dispatch
// Accepts one flow record at a time from the scheduler and dispatches it
// to the retransmit, pure-ACK and data-send engines in rt > ack > data
// priority order. It waits for the payload engine to complete any data
// job, then returns a flag-update command to the scheduler.
//
// Flat port layouts:
//   sched_tx_req_data   = {flowid[FLOWID_W-1:0], rt_flag, ack_flag, data_flag}
//   tx_sched_update_cmd = {flowid[FLOWID_W-1:0], rt_psc[1:0], ack_psc[1:0], data_psc[1:0]}
//   *_psc encodings: 2'b00 no-change, 2'b01 set, 2'b10 clear
module tx_sched_dispatch #(
   parameter int CNT_W    = 32,
   parameter int FLOWID_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sched_tx_req_val,
   input  logic [FLOWID_W+2:0]   sched_tx_req_data,
   output logic                  tx_sched_req_rdy,
   output logic                  rt_req_val,
   output logic [FLOWID_W-1:0]   rt_req_flowid,
   input  logic                  rt_req_rdy,
   output logic                  ack_req_val,
   output logic [FLOWID_W-1:0]   ack_req_flowid,
   input  logic                  ack_req_rdy,
   output logic                  data_req_val,
   output logic [FLOWID_W-1:0]   data_req_flowid,
   input  logic                  data_req_rdy,
   input  logic                  data_resp_val,
   input  logic                  data_resp_more,
   output logic                  data_resp_rdy,
   output logic                  tx_sched_update_val,
   output logic [FLOWID_W+5:0]   tx_sched_update_cmd,
   input  logic                  sched_tx_update_rdy,
   output logic [CNT_W-1:0]      rt_cnt,
   output logic [CNT_W-1:0]      ack_cnt,
   output logic [CNT_W-1:0]      data_cnt
);

   localparam logic [1:0] FLAG_NO_CHANGE = 2'b00;
   localparam logic [1:0] FLAG_SET       = 2'b01;
   localparam logic [1:0] FLAG_CLEAR     = 2'b10;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DISP_RT   = 3'd1,
      DISP_ACK  = 3'd2,
      DISP_DATA = 3'd3,
      WAIT_DATA = 3'd4,
      UPDATE    = 3'd5
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [FLOWID_W-1:0]   flowid_r;
   logic                  pend_rt_r, pend_ack_r, pend_data_r;
   logic                  svc_rt_r, svc_ack_r, svc_data_r;
   logic                  more_r;
   logic                  req_rdy_r, rt_val_r, ack_val_r, data_val_r;
   logic                  resp_rdy_r, upd_val_r;
   logic [CNT_W-1:0]      rt_cnt_r, ack_cnt_r, data_cnt_r;
   logic [1:0]            rt_field_s, ack_field_s, data_field_s;

   logic accept_s, rt_hs_s, ack_hs_s, data_hs_s, resp_hs_s, upd_hs_s;
   logic in_rt_s, in_ack_s, in_data_s;

   assign in_rt_s   = sched_tx_req_data[2];
   assign in_ack_s  = sched_tx_req_data[1];
   assign in_data_s = sched_tx_req_data[0];

   // Handshakes are qualified by the registered valid/ready outputs, which
   // always mirror the current state.
   assign accept_s  = sched_tx_req_val    & req_rdy_r;
   assign rt_hs_s   = rt_val_r            & rt_req_rdy;
   assign ack_hs_s  = ack_val_r           & ack_req_rdy;
   assign data_hs_s = data_val_r          & data_req_rdy;
   assign resp_hs_s = data_resp_val       & resp_rdy_r;
   assign upd_hs_s  = upd_val_r           & sched_tx_update_rdy;

   // Next-state selection: walk the pending jobs in rt > ack > data order.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (in_rt_s)        state_s = DISP_RT;
               else if (in_ack_s)  state_s = DISP_ACK;
               else if (in_data_s) state_s = DISP_DATA;
               else                state_s = UPDATE;
            end else begin
               state_s = IDLE;
            end
         end
         DISP_RT: begin
            if (rt_hs_s) begin
               if (pend_ack_r)       state_s = DISP_ACK;
               else if (pend_data_r) state_s = DISP_DATA;
               else                  state_s = UPDATE;
            end else begin
               state_s = DISP_RT;
            end
         end
         DISP_ACK: begin
            if (ack_hs_s) begin
               if (pend_data_r) state_s = DISP_DATA;
               else             state_s = UPDATE;
            end else begin
               state_s = DISP_ACK;
            end
         end
         DISP_DATA: begin
            if (data_hs_s) state_s = WAIT_DATA;
            else           state_s = DISP_DATA;
         end
         WAIT_DATA: begin
            if (resp_hs_s) state_s = UPDATE;
            else           state_s = WAIT_DATA;
         end
         UPDATE: begin
            if (upd_hs_s) state_s = IDLE;
            else          state_s = UPDATE;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register plus valid/ready outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         req_rdy_r  <= 1'b1;
         rt_val_r   <= 1'b0;
         ack_val_r  <= 1'b0;
         data_val_r <= 1'b0;
         resp_rdy_r <= 1'b0;
         upd_val_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         req_rdy_r  <= (state_s == IDLE);
         rt_val_r   <= (state_s == DISP_RT);
         ack_val_r  <= (state_s == DISP_ACK);
         data_val_r <= (state_s == DISP_DATA);
         resp_rdy_r <= (state_s == WAIT_DATA);
         upd_val_r  <= (state_s == UPDATE);
      end
   end

   // Latch the accepted record and track which jobs were actually serviced.
   always_ff @(posedge clk) begin
      if (rst) begin
         flowid_r    <= {FLOWID_W{1'b0}};
         pend_rt_r   <= 1'b0;
         pend_ack_r  <= 1'b0;
         pend_data_r <= 1'b0;
         svc_rt_r    <= 1'b0;
         svc_ack_r   <= 1'b0;
         svc_data_r  <= 1'b0;
         more_r      <= 1'b0;
      end else if (accept_s) begin
         flowid_r    <= sched_tx_req_data[FLOWID_W+2:3];
         pend_rt_r   <= in_rt_s;
         pend_ack_r  <= in_ack_s;
         pend_data_r <= in_data_s;
         svc_rt_r    <= 1'b0;
         svc_ack_r   <= 1'b0;
         svc_data_r  <= 1'b0;
         more_r      <= 1'b0;
      end else begin
         if (rt_hs_s)   svc_rt_r   <= 1'b1;
         if (ack_hs_s)  svc_ack_r  <= 1'b1;
         if (data_hs_s) svc_data_r <= 1'b1;
         if (resp_hs_s) more_r     <= data_resp_more;
      end
   end

   // Per-type dispatch counters, advanced only on the job handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rt_cnt_r   <= {CNT_W{1'b0}};
         ack_cnt_r  <= {CNT_W{1'b0}};
         data_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (rt_hs_s)   rt_cnt_r   <= rt_cnt_r   + CNT_W'(1'b1);
         if (ack_hs_s)  ack_cnt_r  <= ack_cnt_r  + CNT_W'(1'b1);
         if (data_hs_s) data_cnt_r <= data_cnt_r + CNT_W'(1'b1);
      end
   end

   // Build the flag-update fields; data stays pending while payload remains.
   always_comb begin
      rt_field_s   = FLAG_NO_CHANGE;
      ack_field_s  = FLAG_NO_CHANGE;
      data_field_s = FLAG_NO_CHANGE;
      if (svc_rt_r)  rt_field_s  = FLAG_CLEAR;
      else           rt_field_s  = FLAG_NO_CHANGE;
      if (svc_ack_r) ack_field_s = FLAG_CLEAR;
      else           ack_field_s = FLAG_NO_CHANGE;
      if (svc_data_r && !more_r) data_field_s = FLAG_CLEAR;
      else                       data_field_s = FLAG_NO_CHANGE;
   end

   assign tx_sched_req_rdy    = req_rdy_r;
   assign rt_req_val          = rt_val_r;
   assign ack_req_val         = ack_val_r;
   assign data_req_val        = data_val_r;
   assign data_resp_rdy       = resp_rdy_r;
   assign tx_sched_update_val = upd_val_r;
   assign rt_req_flowid       = flowid_r;
   assign ack_req_flowid      = flowid_r;
   assign data_req_flowid     = flowid_r;
   assign tx_sched_update_cmd = {flowid_r, rt_field_s, ack_field_s, data_field_s};
   assign rt_cnt              = rt_cnt_r;
   assign ack_cnt             = ack_cnt_r;
   assign data_cnt            = data_cnt_r;

endmodule
